pipe_rr_arbiter: RTL

Round-robin arbiter that shares one registered pipeline stage between `p_num_req` requesters using valid/ready handshakes. Each cycle the block selects at most one requester, registers its data and index into a single output stage, and presents them downstream. It sits in front of a pipestage-style datapath register, wherever several producers feed one consumer. It provides fair, full-throughput sharing with backpressure.

---
 rtl/pipe_rr_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter feeding one registered output stage with valid/ready
// handshakes. At most one requester is accepted per cycle. Its data and index
// are registered and presented downstream with one cycle of latency.
module pipe_rr_arbiter #(
  parameter int unsigned p_width   = 32,
  parameter int unsigned p_num_req = 4,
  localparam int unsigned p_id_w   = $clog2(p_num_req)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [p_num_req-1:0]           i_mask,
  input  logic [p_num_req-1:0]           i_req_valid,
  output logic [p_num_req-1:0]           o_req_ready,
  input  logic [p_num_req*p_width-1:0]   i_req_data,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [p_width-1:0]             o_out_data,
  output logic [p_id_w-1:0]              o_out_id
);

  localparam logic [p_id_w-1:0] last_id = p_id_w'(p_num_req - 1);
  localparam logic [p_id_w-1:0] one_id  = p_id_w'(1);
  localparam logic [p_id_w:0]   num_ext = (p_id_w + 1)'(p_num_req);

  logic [p_num_req-1:0] elig;
  logic                 load;
  logic                 transfer;
  logic                 grant_found;
  logic [p_id_w-1:0]    grant_idx;
  logic [p_id_w-1:0]    idx;
  logic [p_id_w:0]      pos;
  logic [p_width-1:0]   sel_data;
  logic [p_id_w-1:0]    rr_ptr;
  logic [p_id_w-1:0]    rr_ptr_next;

  // Stage can take a new item when empty or draining this cycle.
  always_comb begin
    elig     = i_req_valid & i_mask;
    load     = !o_out_valid || i_out_ready;
    transfer = load && grant_found && !i_rst;
  end

  // Search eligible requesters starting at rr_ptr, wrapping to index 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    pos         = '0;
    for (int i = 0; i < p_num_req; i++) begin
      pos = {1'b0, rr_ptr} + (p_id_w + 1)'(i);
      if (pos >= num_ext) begin
        pos = pos - num_ext;
      end
      idx = pos[p_id_w-1:0];
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Select the granted requester's data slice.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < p_num_req; k++) begin
      if (grant_idx == p_id_w'(k)) begin
        sel_data = i_req_data[k*p_width +: p_width];
      end
    end
  end

  // One-hot ready for the granted requester; forced low during reset.
  always_comb begin
    o_req_ready = '0;
    if (transfer) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner, wrapping after the last index.
  always_comb begin
    rr_ptr_next = (grant_idx == last_id) ? '0 : grant_idx + one_id;
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_id    <= '0;
      rr_ptr      <= '0;
    end else if (transfer) begin
      o_out_valid <= 1'b1;
      o_out_data  <= sel_data;
      o_out_id    <= grant_idx;
      rr_ptr      <= rr_ptr_next;
    end else if (o_out_valid && i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

endmodule
